// File: rtl/bmp_input_capture_if.sv
// Pixel-stream / frame-buffer-write bundle for the BMP input capture stage.
// Master drives the line-framed pixel stream and observes the write side.
// Slave (the capture block) consumes pixels and produces writes and status.
interface bmp_input_capture_if #(
  parameter int ADDR_W = 19
);
  logic              Start_in;
  logic              H_Valid_in;
  logic              H_Jump_in;
  logic [23:0]       Bmp_Data_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              busy;
  logic              frame_done;
  logic [2:0]        err_flags;

  modport master (
    output Start_in, H_Valid_in, H_Jump_in, Bmp_Data_in,
    input  wr_en, wr_addr, wr_data, busy, frame_done, err_flags
  );

  modport slave (
    input  Start_in, H_Valid_in, H_Jump_in, Bmp_Data_in,
    output wr_en, wr_addr, wr_data, busy, frame_done, err_flags
  );
endinterface

// File: rtl/bmp_input_capture.sv
// Captures a line-framed 24-bit pixel stream into linear frame-buffer writes.
// Latency: one cycle from pixel sample to registered write strobe/address/data.
// No backpressure: the frame buffer must accept one write every cycle.
// Optional protocol checking (short_line/overrun/abort) enabled by PROTO_CHK_EN.
module bmp_input_capture #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19
) (
  input  logic                 Clk_in,
  input  logic                 Rst_n,
  bmp_input_capture_if.slave   bus
);

  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam logic [XW-1:0]     X_END     = XW'(IMG_W);
  localparam logic [XW-1:0]     X_LASTCOL = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST    = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_W);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              start_prev_q;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]       wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              start_edge;
  logic              capture;
  logic              in_row;
`ifdef PROTO_CHK_EN
  logic [2:0]        err_q, err_d;   // {abort, short_line, overrun}
`endif

  // Next-state, pixel acceptance and address generation.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    addr_d     = addr_q;
    base_d     = base_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    capture    = 1'b0;
    start_edge = bus.Start_in && !start_prev_q;
    in_row     = (x_q < X_END) && (y_q <= Y_LAST);
`ifdef PROTO_CHK_EN
    err_d      = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        // A pixel arriving with the start edge belongs to the new frame.
        if (start_edge) begin
          state_d = S_ACTIVE;
          capture = 1'b1;
`ifdef PROTO_CHK_EN
          err_d   = 3'b000;
`endif
        end
      end
      S_ACTIVE: begin
        if (!bus.Start_in) begin
          state_d = S_IDLE;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          base_d  = '0;
`ifdef PROTO_CHK_EN
          err_d[2] = 1'b1;
`endif
        end else begin
          capture = 1'b1;
        end
      end
      S_DONE: begin
        // Trailing pixels are dropped silently until Start_in falls.
        if (!bus.Start_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (capture && bus.H_Valid_in) begin
      if (in_row) begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = bus.Bmp_Data_in;
      end else begin
`ifdef PROTO_CHK_EN
        err_d[0] = 1'b1;
`endif
      end

      if (bus.H_Jump_in) begin
`ifdef PROTO_CHK_EN
        if (x_q < X_LASTCOL) err_d[1] = 1'b1;
`endif
        // Next line base is accumulated, so no multiplier is needed.
        x_d    = '0;
        y_d    = y_q + YW'(1);
        base_d = base_q + LINE_STEP;
        addr_d = base_q + LINE_STEP;
        if (y_q == Y_LAST) begin
          done_d  = 1'b1;
          state_d = S_DONE;
          y_d     = '0;
          base_d  = '0;
          addr_d  = '0;
        end
      end else if (in_row) begin
        x_d    = x_q + XW'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
      // Valid without jump past the last column: x saturates at IMG_W.
    end
  end

  // State, counters and registered write port.
  always_ff @(posedge Clk_in or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      base_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= bus.Start_in;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      base_q       <= base_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
    end
  end

`ifdef PROTO_CHK_EN
  // Sticky protocol error flags, cleared on a new frame start.
  always_ff @(posedge Clk_in or negedge Rst_n) begin
    if (!Rst_n) err_q <= 3'b000;
    else        err_q <= err_d;
  end
  assign bus.err_flags = err_q;
`else
  assign bus.err_flags = 3'b000;
`endif

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.frame_done = done_q;
  assign bus.busy       = (state_q == S_ACTIVE);

endmodule
